regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and requester ids for the register-file writeback arbiter.
package regfile_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int NREG_DEF = 2 ** AW_DEF;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant logic; rr_ptr names the requester favoured on contention.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    a_valid_i,
  input  logic    b_valid_i,
  output logic    a_grant_o,
  output logic    b_grant_o,
  output req_id_e rr_ptr_o
);

  req_id_e ptr_q, ptr_d;

  // A lone requester always wins; the pointer only matters when both ask.
  always_comb begin
    a_grant_o = 1'b0;
    b_grant_o = 1'b0;
    if (!rst_i) begin
      if (a_valid_i && (!b_valid_i || ptr_q == REQ_A)) begin
        a_grant_o = 1'b1;
      end else if (b_valid_i) begin
        b_grant_o = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (a_grant_o) begin
      ptr_d = other_req(REQ_A);
    end else if (b_grant_o) begin
      ptr_d = other_req(REQ_B);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign rr_ptr_o = ptr_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU (A) and load (B) writebacks onto one registered
// write port and tracks outstanding destinations. REGFILE_ZERO_REG_EN hard-wires register 0.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [AW-1:0]     a_rd,
  input  logic [DW-1:0]     a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [AW-1:0]     b_rd,
  input  logic [DW-1:0]     b_data,
  output logic              b_ready,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              write,
  output logic [AW-1:0]     rd,
  output logic [DW-1:0]     data,
  output logic [2**AW-1:0]  pending,
  output logic              rr_ptr
);

  localparam int NREG = 2 ** AW;

  // Handshake: a transfer completes when valid && ready are high in the same
  // cycle; requesters hold rd/data stable until then. Ready never depends on rd/data.
  logic    a_grant, b_grant, hs;
  req_id_e rr_ptr_id;

  rr_arb2 u_arb (
    .clk_i     (clk),
    .rst_i     (rst),
    .a_valid_i (a_valid),
    .b_valid_i (b_valid),
    .a_grant_o (a_grant),
    .b_grant_o (b_grant),
    .rr_ptr_o  (rr_ptr_id)
  );

  assign a_ready = a_grant;
  assign b_ready = b_grant;
  assign rr_ptr  = rr_ptr_id;
  assign hs      = a_grant | b_grant;

  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic            wr_en, iss_en;
  logic            write_q;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   data_q;
  logic [NREG-1:0] pending_q, pending_d;

  assign sel_rd   = b_grant ? b_rd   : a_rd;
  assign sel_data = b_grant ? b_data : a_data;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_en  = hs && (sel_rd != '0);
  assign iss_en = iss_valid && (iss_rd != '0);
`else
  assign wr_en  = hs;
  assign iss_en = iss_valid;
`endif

  // Set is applied after clear so a new producer of the same index wins.
  always_comb begin
    pending_d = pending_q;
    if (hs) begin
      pending_d[sel_rd] = 1'b0;
    end
    if (iss_en) begin
      pending_d[iss_rd] = 1'b1;
    end
`ifdef REGFILE_ZERO_REG_EN
    pending_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q   <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      write_q   <= wr_en;
      pending_q <= pending_d;
      if (wr_en) begin
        rd_q   <= sel_rd;
        data_q <= sel_data;
      end
    end
  end

  assign write   = write_q;
  assign rd      = rd_q;
  assign data    = data_q;
  assign pending = pending_q;

endmodule
